// File: rtl/array_tile_loader.sv
// Array tile loader: collects an 8-word serial stream into a pair of 2x2 tiles
// (A then B) and presents them to a downstream array with a valid/ready handshake.
// A one-deep fill buffer lets the next pair stream in while the current pair is held.
// Optional feature macro: TILE_LOADER_TRANSPOSE_EN stores tile B column-major.
module array_tile_loader #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A [2][2],
  output logic [WIDTH-1:0] B [2][2],
  output logic             TILE_VALID,
  input  logic             TILE_READY,
  output logic             ERR
);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e           state_q;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] buf_a [2][2];
  logic [WIDTH-1:0] buf_b [2][2];
  logic [WIDTH-1:0] a_q   [2][2];
  logic [WIDTH-1:0] b_q   [2][2];
  logic             tile_valid_q;
  logic             err_q;
  logic             accept;
  logic             b_row;
  logic             b_col;

  // Ready is forced low while reset is being sampled so no word slips in.
  assign IN_READY = (state_q == StFill) && !RST;
  assign accept   = IN_VALID && IN_READY;

`ifdef TILE_LOADER_TRANSPOSE_EN
  assign b_row = cnt_q[0];
  assign b_col = cnt_q[1];
`else
  assign b_row = cnt_q[1];
  assign b_col = cnt_q[0];
`endif

  assign A          = a_q;
  assign B          = b_q;
  assign TILE_VALID = tile_valid_q;
  assign ERR        = err_q;

  // Fill/full FSM, word counter, fill buffer, output registers and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StFill;
      cnt_q        <= '0;
      tile_valid_q <= 1'b0;
      err_q        <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          buf_a[r][c] <= '0;
          buf_b[r][c] <= '0;
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
        end
      end
    end else begin
      // Consumer took the tile; a copy below overrides this with new data.
      if (tile_valid_q && TILE_READY) begin
        tile_valid_q <= 1'b0;
      end
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (IN_LAST && cnt_q != 3'd7) begin
              // Early LAST: drop the partial pair and resynchronise.
              err_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              if (cnt_q[2]) begin
                buf_b[b_row][b_col] <= IN_DATA;
              end else begin
                buf_a[cnt_q[1]][cnt_q[0]] <= IN_DATA;
              end
              if (cnt_q == 3'd7) begin
                state_q <= StFull;
                cnt_q   <= '0;
                // Missing LAST on the final word is flagged but the pair still completes.
                if (!IN_LAST) begin
                  err_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end
        end
        StFull: begin
          if (!tile_valid_q || TILE_READY) begin
            a_q          <= buf_a;
            b_q          <= buf_b;
            tile_valid_q <= 1'b1;
            state_q      <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_array_tile_loader.sv
// Self-checking bench for array_tile_loader: directed streams, expected tiles
// queued at stimulus time and checked by an independent monitor on each handshake.
module tb_array_tile_loader;

  localparam int unsigned WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] IN_DATA = '0;
  logic             IN_VALID = 1'b0;
  logic             IN_LAST = 1'b0;
  logic             IN_READY;
  logic [WIDTH-1:0] A [2][2];
  logic [WIDTH-1:0] B [2][2];
  logic             TILE_VALID;
  logic             TILE_READY = 1'b1;
  logic             ERR;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];

`ifdef TILE_LOADER_TRANSPOSE_EN
  localparam logic [127:0] Tile10 = 128'h0010_0011_0012_0013_0014_0016_0015_0017;
`else
  localparam logic [127:0] Tile10 = 128'h0010_0011_0012_0013_0014_0015_0016_0017;
`endif

  array_tile_loader #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .TILE_VALID(TILE_VALID),
    .TILE_READY(TILE_READY),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] pack_out();
    return {A[0][0], A[0][1], A[1][0], A[1][1], B[0][0], B[0][1], B[1][0], B[1][1]};
  endfunction

  // Expected pair for a stream base, base+1, ... base+7.
  function automatic logic [127:0] mk(input logic [15:0] base);
    logic [15:0] w [8];
    for (int i = 0; i < 8; i++) w[i] = base + 16'(i);
`ifdef TILE_LOADER_TRANSPOSE_EN
    return {w[0], w[1], w[2], w[3], w[4], w[6], w[5], w[7]};
`else
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Monitor: every tile handshake must match the next queued expectation.
  always @(negedge CLK) begin
    if (!RST && TILE_VALID && TILE_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tile: got %h, required no tile", pack_out());
      end else begin
        check("tile", pack_out(), exp_q.pop_front());
      end
    end
  end

  // Called and returns at posedge+1; holds the word until accepted.
  task automatic send_word(input logic [15:0] data, input logic last);
    logic ok;
    int   n;
    IN_DATA  = data;
    IN_LAST  = last;
    IN_VALID = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge CLK);
      ok = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got IN_READY low for %0d cycles, required word %h taken", n, data);
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] base, input logic with_last, input logic gap);
    for (int i = 0; i < 8; i++) begin
      send_word(base + 16'(i), with_last && (i == 7));
      if (gap) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check(name, 128'(exp_q.size()), 128'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge CLK);
    check({name, "_in_ready"}, 128'(IN_READY), 128'd1);
    check({name, "_tile_valid"}, 128'(TILE_VALID), 128'd0);
    check({name, "_err"}, 128'(ERR), 128'd0);
    check({name, "_ab_zero"}, pack_out(), 128'd0);
  endtask

  initial begin
    // Reset: ready low while reset sampled, clean state afterwards.
    RST = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", 128'(IN_READY), 128'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_state("post_reset");
    @(posedge CLK);
    #1;

    // Basic pair, one-cycle latency, valid for exactly one cycle.
    TILE_READY = 1'b1;
    exp_q.push_back(Tile10);
    send_pair(16'h0010, 1'b1, 1'b0);
    @(negedge CLK);
    check("latency_not_yet", 128'(TILE_VALID), 128'd0);
    @(negedge CLK);
    check("latency_valid", 128'(TILE_VALID), 128'd1);
    @(negedge CLK);
    check("valid_one_cycle", 128'(TILE_VALID), 128'd0);
    check("basic_err", 128'(ERR), 128'd0);
    @(posedge CLK);
    #1;
    drain("basic_drain");

    // IN_VALID every other cycle: identical tile.
    exp_q.push_back(Tile10);
    send_pair(16'h0010, 1'b1, 1'b1);
    drain("gap_drain");

    // Early LAST on 3rd word: error, no tile, then a clean pair.
    send_word(16'h00F0, 1'b0);
    send_word(16'h00F1, 1'b0);
    send_word(16'h00F2, 1'b1);
    @(negedge CLK);
    check("early_last_err", 128'(ERR), 128'd1);
    check("early_last_no_tile", 128'(TILE_VALID), 128'd0);
    @(posedge CLK);
    #1;
    exp_q.push_back(mk(16'h0100));
    send_pair(16'h0100, 1'b1, 1'b0);
    drain("recover_drain");
    check("err_sticky", 128'(ERR), 128'd1);

    // Reset mid-tile after 5 words.
    for (int i = 0; i < 5; i++) send_word(16'h0200 + 16'(i), 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check("midtile_rst_in_ready", 128'(IN_READY), 128'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_state("midtile_reset");
    @(posedge CLK);
    #1;
    exp_q.push_back(mk(16'h0300));
    send_pair(16'h0300, 1'b1, 1'b0);
    drain("post_rst_drain");

    // Backpressure: two pairs with consumer stalled.
    TILE_READY = 1'b0;
    exp_q.push_back(mk(16'h0400));
    exp_q.push_back(mk(16'h0500));
    send_pair(16'h0400, 1'b1, 1'b0);
    send_pair(16'h0500, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_in_ready", 128'(IN_READY), 128'd0);
      check("stall_valid", 128'(TILE_VALID), 128'd1);
      check("stall_hold", pack_out(), mk(16'h0400));
    end
    @(posedge CLK);
    #1;
    TILE_READY = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("second_pair_valid", 128'(TILE_VALID), 128'd1);
    check("second_pair_data", pack_out(), mk(16'h0500));
    check("second_pair_in_ready", 128'(IN_READY), 128'd1);
    @(posedge CLK);
    #1;
    drain("stall_drain");
    check("stall_err", 128'(ERR), 128'd0);

    // Missing LAST on word 7: tile completes, error set.
    exp_q.push_back(mk(16'h0600));
    send_pair(16'h0600, 1'b0, 1'b0);
    drain("no_last_drain");
    check("no_last_err", 128'(ERR), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
